// File: rtl/conv_pkg.sv
// Shared definitions for the 5x5 convolution datapath: kernel size,
// default pixel width and the window array type exchanged between stages.
package conv_pkg;

    localparam int KSIZE    = 5;
    localparam int BITWIDTH = 16;
    localparam int LB_COUNT = KSIZE - 1;

    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef pixel_t window_t [KSIZE-1:0][KSIZE-1:0];

    // Address width for a store of the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage. Read and write share the column address so the
// old pixel at a column is read in the same cycle it is replaced.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int DEPTH    = 28,
    parameter int AW       = addr_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [AW-1:0]              addr,
    input  logic signed [bitwidth-1:0] wr_data,
    output logic signed [bitwidth-1:0] rd_data
);

    logic signed [bitwidth-1:0] mem [DEPTH];

    // Contents are never exposed before being rewritten, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming line buffer feeding the 5x5 convolution point: takes raster-order
// pixels and presents every fully valid 5x5 neighbourhood as a registered window.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [bitwidth-1:0] in_pixel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [bitwidth-1:0] map_block [KSIZE-1:0][KSIZE-1:0],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int COL_W = addr_width(IMG_W);
    localparam int ROW_W = addr_width(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KSIZE - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             win_pos;
    logic             frame_end;

    logic signed [bitwidth-1:0] lb_rd [LB_COUNT];
    logic signed [bitwidth-1:0] lb_wr [LB_COUNT];

    assign in_ready  = rst_n && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign win_pos   = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    // Buffer 0 holds the oldest row; each accept moves a column up one buffer.
    for (genvar k = 0; k < LB_COUNT; k++) begin : g_lb
        if (k == LB_COUNT - 1) begin : g_newest
            assign lb_wr[k] = in_pixel;
        end else begin : g_cascade
            assign lb_wr[k] = lb_rd[k+1];
        end

        conv_line_buffer #(
            .bitwidth (bitwidth),
            .DEPTH    (IMG_W),
            .AW       (COL_W)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (col),
            .wr_data (lb_wr[k]),
            .rd_data (lb_rd[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // The window shifts on every accept, including the suppressed columns that
    // straddle a row wrap, so it is already aligned when col reaches KSIZE-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    map_block[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    map_block[r][c] <= map_block[r][c+1];
                end
            end
            for (int r = 0; r < LB_COUNT; r++) begin
                map_block[r][KSIZE-1] <= lb_rd[r];
            end
            map_block[KSIZE-1][KSIZE-1] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= win_pos;
            out_last  <= win_pos && frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer on an 8x8 image: window contents and
// ordering, frame wrap, backpressure, random handshakes and asynchronous reset.
module tb_conv_window_buffer;
    import conv_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NW = (W - 4) * (H - 4);

    logic                clk;
    logic                rst_n;
    logic signed [15:0]  in_pixel;
    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  map_block [KSIZE-1:0][KSIZE-1:0];
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    conv_window_buffer #(
        .bitwidth (16),
        .IMG_W    (W),
        .IMG_H    (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .map_block (map_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [24:0][15:0] px;
        logic              last;
    } cap_t;

    typedef struct {
        int win;
        int e00;
        int e04;
        int e40;
        int e44;
        int last;
    } vec_t;

    cap_t cap[$];
    vec_t tbl[6];
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    function automatic logic [24:0][15:0] flat();
        logic [24:0][15:0] f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f[r*5+c] = map_block[r][c];
        return f;
    endfunction

    // Frame f of a run carries 100*f + row*8 + col.
    function automatic logic [15:0] pix(input int idx);
        return 16'((idx / 64) * 100 + (idx % 64));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero_window(input string name);
        int nz = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (map_block[r][c] !== 16'sd0) nz++;
        chk(name, nz, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            cap.push_back('{px: flat(), last: out_last});
    end

    // Called at posedge+1; returns at posedge+1.
    task automatic drive(input int nframes, input bit rnd, input int stall_key, input int rst_at);
        int idx = 0;
        int guard = 0;
        int lat = -1;
        bit acc;
        bit stalled = 0;
        bit did_rst = 0;
        logic [24:0][15:0] snap;
        while (idx < nframes * 64) begin
            guard++;
            if (guard > 5000) begin
                chk("drive timeout: pixels accepted", idx, nframes * 64);
                break;
            end
            if (rst_at >= 0 && !did_rst && idx == rst_at) begin
                did_rst = 1;
                chk("pre-reset out_valid", out_valid, 1);
                rst_n = 1'b0;
                #1;
                chk("async reset out_valid", out_valid, 0);
                chk("async reset out_last", out_last, 0);
                chk("async reset in_ready", in_ready, 0);
                chk_zero_window("async reset map_block zero");
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                idx = 0;
                lat = -1;
                cap.delete();
            end
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel  = pix(idx);
            if (stall_key >= 0 && !stalled && out_valid && map_block[4][4] == 16'(stall_key)) begin
                stalled = 1;
                snap = flat();
                out_ready = 1'b0;
                in_valid = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall in_ready", in_ready, 0);
                    chk("stall out_valid", out_valid, 1);
                    chk("stall map_block stable", flat() == snap, 1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (lat == 35) chk("out_valid after pixel 35", out_valid, 0);
            if (lat == 36) begin
                chk("out_valid after pixel 36", out_valid, 1);
                chk("first window [4][4]", map_block[4][4], 36);
            end
            lat = -1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx < 64) lat = idx;
                idx++;
            end
        end
        if (stall_key >= 0) chk("stall occurred", stalled, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: window at (row,col) of frame f holds 100f + (row-4+r)*8 + (col-4+c).
    task automatic check_frames(input string tag, input int nf);
        int n = 0;
        int lasts = 0;
        chk({tag, " window count"}, cap.size(), nf * NW);
        foreach (cap[i]) lasts += int'(cap[i].last);
        chk({tag, " out_last count"}, lasts, nf);
        for (int f = 0; f < nf; f++) begin
            for (int row = 4; row < H; row++) begin
                for (int col = 4; col < W; col++) begin
                    if (n < cap.size()) begin
                        int br;
                        int bc;
                        bit found;
                        br = 4;
                        bc = 4;
                        found = 0;
                        for (int r = 0; r < 5; r++)
                            for (int c = 0; c < 5; c++)
                                if (!found && cap[n].px[r*5+c] !== 16'(f*100 + (row-4+r)*W + (col-4+c))) begin
                                    found = 1;
                                    br = r;
                                    bc = c;
                                end
                        chk($sformatf("%s win%0d [%0d][%0d]", tag, n, br, bc),
                            32'(cap[n].px[br*5+bc]), f*100 + (row-4+br)*W + (col-4+bc));
                        chk($sformatf("%s win%0d out_last", tag, n),
                            32'(cap[n].last), (row == H-1 && col == W-1) ? 1 : 0);
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{win: 0,  e00: 0,   e04: 4,   e40: 32,  e44: 36,  last: 0};
        tbl[1] = '{win: 3,  e00: 3,   e04: 7,   e40: 35,  e44: 39,  last: 0};
        tbl[2] = '{win: 4,  e00: 8,   e04: 12,  e40: 40,  e44: 44,  last: 0};
        tbl[3] = '{win: 15, e00: 27,  e04: 31,  e40: 59,  e44: 63,  last: 1};
        tbl[4] = '{win: 16, e00: 100, e04: 104, e40: 132, e44: 136, last: 0};
        tbl[5] = '{win: 31, e00: 127, e04: 131, e40: 159, e44: 163, last: 1};

        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 16'h1234;
        out_ready = 1'b1;

        @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk_zero_window("reset map_block zero");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Two back-to-back frames at full throughput.
        cap.delete();
        drive(2, 1'b0, -1, -1);
        check_frames("b2b", 2);
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].win < cap.size()) begin
                chk($sformatf("tbl%0d [0][0]", i), 32'(cap[tbl[i].win].px[0]),  tbl[i].e00);
                chk($sformatf("tbl%0d [0][4]", i), 32'(cap[tbl[i].win].px[4]),  tbl[i].e04);
                chk($sformatf("tbl%0d [4][0]", i), 32'(cap[tbl[i].win].px[20]), tbl[i].e40);
                chk($sformatf("tbl%0d [4][4]", i), 32'(cap[tbl[i].win].px[24]), tbl[i].e44);
                chk($sformatf("tbl%0d last", i),   32'(cap[tbl[i].win].last),   tbl[i].last);
            end else begin
                chk($sformatf("tbl%0d window present", i), 0, 1);
            end
        end

        // Backpressure on the window ending in pixel 37.
        pulse_reset();
        cap.delete();
        drive(1, 1'b0, 37, -1);
        check_frames("stall", 1);
        if (cap.size() > 2) chk("window after stall [4][4]", 32'(cap[2].px[24]), 38);

        // Random handshakes over three frames.
        pulse_reset();
        cap.delete();
        drive(3, 1'b1, -1, -1);
        check_frames("random", 3);

        // Asynchronous reset after pixel 39, then a fresh frame.
        pulse_reset();
        cap.delete();
        drive(1, 1'b0, -1, 40);
        check_frames("reset", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Streaming line-buffer stage directly upstream of the 5x5 convolution point.
- Accepts one feature-map pixel per handshake in raster order (row-major, left to right).
- Presents each fully valid 5x5 neighbourhood as a registered window array for the convolution stage to consume. No padding is applied: valid convolution only, with output size (IMG_W-4)x(IMG_H-4) per frame.

Parameters:
- bitwidth, 16, pixel width in bits, signed.
- IMG_W, 28, pixels per row; must be at least 5.
- IMG_H, 28, rows per frame; must be at least 5.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_pixel  input  signed [bitwidth-1:0]  incoming pixel.
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block accepts in_pixel this cycle.
- map_block  output  signed [bitwidth-1:0] [4:0][4:0] (unpacked)  current window; element [r][c] is the pixel at (row-4+r, col-4+c).
- out_valid  output  1  map_block holds a valid window.
- out_ready  input  1  downstream consumes the window.
- out_last  output  1  window is the final window of the frame; qualified by out_valid.

Behaviour:
- Reset values: in_ready=0 while rst_n is low. out_valid=0, out_last=0, map_block all 0. Row/column counters are 0. Line-buffer contents are don't-care.
- Accept rule: a pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, with rst_n high.
  - Accepting a pixel never overwrites an unconsumed window.
- Storage:
  - 4 line buffers, each IMG_W deep, hold the previous 4 rows.
  - A 5x5 window register shifts left by one column per accepted pixel.
  - New column c=4: rows 0..3 are read from the line buffers at the current column, oldest row to r=0. Row 4 takes in_pixel.
  - Line buffers are updated in the same cycle as a cascade: each buffer takes the value of the row below, and the newest buffer takes in_pixel.
- Counters:
  - col increments on each accept and wraps from IMG_W-1 to 0.
  - row increments on col wrap and wraps from IMG_H-1 to 0, which starts the next frame.
- Window valid: on the accepting edge, out_valid is set to 1 when the accepted pixel has row>=4 and col>=4. Otherwise out_valid clears if out_ready was high.
- Latency: exactly 1 cycle from the accepting edge to out_valid/map_block.
- Row boundary: windows at col 0..3 straddle the wrap. They are suppressed, never flagged valid, and the window register still shifts.
- out_last is set with the window at row IMG_H-1, col IMG_W-1.
- Frame boundary: the next frame begins immediately, with no idle cycle needed. The line buffers' stale contents are never exposed because rows 0..3 are suppressed.
- Backpressure: while out_valid && !out_ready, map_block, out_valid and out_last hold stable and in_ready=0.
- Simultaneous out_ready and in_valid with out_valid=1: the old window retires and the new pixel is accepted in the same cycle, sustaining full throughput of 1 window per cycle.
- Reset mid-frame: counters return to 0, and the next accepted pixel is treated as (0,0) of a fresh frame. Any pending window is dropped.

Decomposition:
- Shared package conv_pkg holds:
  - localparam KSIZE=5, used by this block and the convolution point.
  - typedef of the 5x5 window array type, parameterised by bitwidth through a package-level default of 16.
- One natural sub-module, conv_line_buffer: a single-row circular store of depth IMG_W with write-enable and a shared column address. It is instantiated 4 times.

Test Plan:
- Reset then frame, IMG_W=IMG_H=8, pixel=row*8+col, in_valid constant, out_ready=1 -> first out_valid one cycle after pixel 36 is accepted; map_block[0][0]=0, map_block[0][4]=4, map_block[4][0]=32, map_block[4][4]=36.
- Same frame -> exactly 16 windows with out_valid. The window after (row4,col7) centre has [4][4]=44 (row5,col4), and no window is issued for row5 col0..3. out_last is asserted only on the window with [4][4]=63.
- Back-to-back frames, second frame pixel=100+row*8+col -> the first window of frame 2 has [0][0]=100 and [4][4]=136, with no frame-1 data visible.
- Backpressure: hold out_ready=0 for 5 cycles on the window with [4][4]=37 -> in_ready=0 and map_block stays stable. On release, the next window is [4][4]=38 with no pixels lost.
- Random in_valid/out_ready toggling (50%) over 3 frames -> the window sequence matches the full-throughput reference model, with 48 windows and 3 out_last pulses.
- Assert rst_n low at pixel 40 for 2 cycles -> out_valid=0 and map_block=0 immediately (asynchronously). Restarting a fresh frame gives the first window at accepted pixel index 36.
